// File: rtl/fast9_pkg.sv
// Shared types and defaults for the FAST-9 corner position buffer.
// Holds the collect/drain state encoding and default geometry.
package fast9_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } buf_state_t;

endpackage

// File: rtl/pos_regfile.sv
// DEPTH x ADDR_W corner address storage.
// One synchronous write port, whole array visible combinationally.
module pos_regfile #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [PTR_W-1:0]              waddr,
  input  logic [ADDR_W-1:0]             wdata,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ents
);

  logic [DEPTH-1:0][ADDR_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ents = mem;

endmodule

// File: rtl/corner_pos_buf.sv
// Frame corner buffer: collects corner addresses, then drains in order.
// position always shows the unread corners starting at the read pointer.
module corner_pos_buf
  import fast9_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frameStart,
  input  logic                     matPoint,
  input  logic [ADDR_W-1:0]        refAddr,
  input  logic                     drainStart,
  input  logic                     rdReq,
  output logic [ADDR_W-1:0]        rdData,
  output logic                     rdValid,
  output logic [DEPTH*ADDR_W-1:0]  position,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic                     overflow,
  output logic                     draining
);

  localparam int PTR_W = $clog2(DEPTH);

  buf_state_t                   state;
  logic [PTR_W-1:0]             wrPtr;
  logic [PTR_W-1:0]             rdPtr;
  logic [DEPTH-1:0][ADDR_W-1:0] ents;
  logic                         we;
  logic                         pop;
  logic [PTR_W:0]               idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign draining = (state == DRAIN);
  assign rdValid  = draining && (count != '0);
  assign pop      = rdReq && rdValid;
  assign we       = !rst && !frameStart && (state == COLLECT)
                    && matPoint && !full;
  assign rdData   = ents[rdPtr];

  pos_regfile #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wrPtr),
    .wdata (refAddr),
    .ents  (ents)
  );

  always_ff @(posedge clk) begin
    if (rst || frameStart) begin
      state    <= COLLECT;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (matPoint) begin
            if (!full) begin
              wrPtr <= ptr_inc(wrPtr);
              count <= count + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          if (drainStart) state <= DRAIN;
        end
        DRAIN: begin
          if (matPoint) overflow <= 1'b1;
          if (pop) begin
            rdPtr <= ptr_inc(rdPtr);
            count <= count - 1'b1;
            // last pop: back to collecting with fresh pointers
            if (count == CNT_W'(1)) begin
              state <= COLLECT;
              wrPtr <= '0;
              rdPtr <= '0;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // rotate storage so entry 0 of position is the current head
  always_comb begin
    position = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = {1'b0, rdPtr} + (PTR_W + 1)'(i);
      if (idx >= (PTR_W + 1)'(DEPTH)) idx = idx - (PTR_W + 1)'(DEPTH);
      if (CNT_W'(i) < count)
        position[(DEPTH-1-i)*ADDR_W +: ADDR_W] = ents[idx[PTR_W-1:0]];
    end
  end

endmodule

// File: tb/tb_corner_pos_buf.sv
// Self-checking bench for corner_pos_buf against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_corner_pos_buf;

  localparam int AW = 15;
  localparam int DP = 16;
  localparam int CW = $clog2(DP + 1);

  logic              clk = 0;
  logic              rst = 0;
  logic              frameStart = 0;
  logic              matPoint = 0;
  logic [AW-1:0]     refAddr = '0;
  logic              drainStart = 0;
  logic              rdReq = 0;
  logic [AW-1:0]     rdData;
  logic              rdValid;
  logic [DP*AW-1:0]  position;
  logic [CW-1:0]     count;
  logic              full;
  logic              overflow;
  logic              draining;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] q[$];
  bit m_ovf;
  bit m_drain;

  corner_pos_buf #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .frameStart (frameStart),
    .matPoint   (matPoint),
    .refAddr    (refAddr),
    .drainStart (drainStart),
    .rdReq      (rdReq),
    .rdData     (rdData),
    .rdValid    (rdValid),
    .position   (position),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .draining   (draining)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, fs, mp, input logic [AW-1:0] a,
                            input bit ds, rr);
    if (r || fs) begin
      q.delete();
      m_ovf = 0;
      m_drain = 0;
    end else if (!m_drain) begin
      if (mp) begin
        if (q.size() < DP) q.push_back(a);
        else m_ovf = 1;
      end
      if (ds) m_drain = 1;
    end else begin
      if (mp) m_ovf = 1;
      if (rr && q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) m_drain = 0;
      end
    end
  endtask

  task automatic tick(input bit r, fs, mp, input logic [AW-1:0] a,
                      input bit ds, rr);
    rst = r; frameStart = fs; matPoint = mp;
    refAddr = a; drainStart = ds; rdReq = rr;
    @(posedge clk);
    model_step(r, fs, mp, a, ds, rr);
    #1;
    rst = 0; frameStart = 0; matPoint = 0;
    refAddr = '0; drainStart = 0; rdReq = 0;
  endtask

  task automatic test_reset();
    tick(1, 0, 1, 15'h1234, 1, 1);
    checks++;
    if (count !== '0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if ({rdValid, full, draining, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {rdValid, full, draining, overflow});
    end
    checks++;
    if (position !== '0) begin
      errors++; $display("FAIL reset_position got=%h exp=0", position);
    end
  endtask

  task automatic test_fill5();
    logic [DP*AW-1:0] exp;
    exp = '0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, AW'(16'h0101 + i), 0, 0);
      exp[(DP-1-i)*AW +: AW] = AW'(16'h0101 + i);
    end
    checks++;
    if (count !== CW'(5)) begin
      errors++; $display("FAIL fill5_count got=%0d exp=5", count);
    end
    checks++;
    if (position !== exp) begin
      errors++; $display("FAIL fill5_position got=%h exp=%h", position, exp);
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] a[17];
    tick(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      a[i] = AW'($urandom);
      tick(0, 0, 1, a[i], 0, 0);
      if (i == 15) begin
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full16 got full=%b ovf=%b exp full=1 ovf=0",
                   full, overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || count !== CW'(16)) begin
      errors++;
      $display("FAIL ovf_17th got ovf=%b cnt=%0d exp ovf=1 cnt=16",
               overflow, count);
    end
    checks++;
    if (position[AW-1:0] !== a[15]) begin
      errors++;
      $display("FAIL ovf_entry15 got=%h exp=%h", position[AW-1:0], a[15]);
    end
  endtask

  task automatic test_drain();
    logic [AW-1:0] a[16];
    int bad;
    tick(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      a[i] = AW'($urandom);
      tick(0, 0, 1, a[i], 0, 0);
    end
    tick(0, 0, 0, '0, 1, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rdValid !== 1'b1 || rdData !== a[i]) begin
        errors++; bad++;
        $display("FAIL drain_pop%0d got v=%b d=%h exp v=1 d=%h",
                 i, rdValid, rdData, a[i]);
      end
      tick(0, 0, 0, '0, 0, 1);
    end
    checks++;
    if (rdValid !== 1'b0 || draining !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL drain_end got v=%b drn=%b cnt=%0d exp 0 0 0",
               rdValid, draining, count);
    end
  endtask

  task automatic test_frame_priority();
    tick(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, AW'(16'h0200 + i), 0, 0);
    tick(0, 1, 1, 15'h1234, 0, 0);
    checks++;
    if (count !== '0 || overflow !== 1'b0 || draining !== 1'b0) begin
      errors++;
      $display("FAIL fs_prio got cnt=%0d ovf=%b drn=%b exp 0 0 0",
               count, overflow, draining);
    end
    checks++;
    if (position !== '0) begin
      errors++; $display("FAIL fs_prio_pos got=%h exp=0", position);
    end
    tick(0, 0, 1, 15'h0042, 0, 0);
    checks++;
    if (count !== CW'(1) || position[DP*AW-1 -: AW] !== 15'h0042) begin
      errors++;
      $display("FAIL fs_rewrite got cnt=%0d e0=%h exp cnt=1 e0=0042",
               count, position[DP*AW-1 -: AW]);
    end
  endtask

  task automatic test_write_drain();
    tick(0, 1, 0, '0, 0, 0);
    tick(0, 0, 1, 15'h0011, 0, 0);
    tick(0, 0, 1, 15'h0022, 0, 0);
    tick(0, 0, 1, 15'h7FFF, 1, 0);
    checks++;
    if (count !== CW'(3) || draining !== 1'b1) begin
      errors++;
      $display("FAIL wr_drain got cnt=%0d drn=%b exp cnt=3 drn=1",
               count, draining);
    end
    tick(0, 0, 0, '0, 0, 1);
    tick(0, 0, 0, '0, 0, 1);
    checks++;
    if (rdValid !== 1'b1 || rdData !== 15'h7FFF) begin
      errors++;
      $display("FAIL wr_drain_third got v=%b d=%h exp v=1 d=7fff",
               rdValid, rdData);
    end
    tick(0, 0, 1, '0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || count !== CW'(1)) begin
      errors++;
      $display("FAIL drain_matpoint got ovf=%b cnt=%0d exp ovf=1 cnt=1",
               overflow, count);
    end
  endtask

  task automatic test_empty_drain();
    tick(0, 1, 0, '0, 0, 0);
    tick(0, 0, 0, '0, 1, 0);
    tick(0, 0, 0, '0, 0, 1);
    checks++;
    if (draining !== 1'b1 || rdValid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL empty_drain got drn=%b v=%b cnt=%0d exp 1 0 0",
               draining, rdValid, count);
    end
    tick(0, 1, 0, '0, 0, 0);
    checks++;
    if (draining !== 1'b0) begin
      errors++; $display("FAIL empty_drain_exit got drn=%b exp 0", draining);
    end
  endtask

  task automatic test_rst_mid_drain();
    tick(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, AW'($urandom), 0, 0);
    tick(0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, '0, 0, 1);
    checks++;
    if (count !== CW'(7)) begin
      errors++; $display("FAIL mid_drain_count got=%0d exp=7", count);
    end
    tick(1, 0, 0, '0, 0, 1);
    checks++;
    if (count !== '0 || draining !== 1'b0 || position !== '0) begin
      errors++;
      $display("FAIL rst_mid_drain got cnt=%0d drn=%b pos=%h exp 0 0 0",
               count, draining, position);
    end
  endtask

  task automatic test_random();
    logic [DP*AW-1:0] exp;
    for (int c = 0; c < 1500; c++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1, AW'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
      exp = '0;
      foreach (q[i]) exp[(DP-1-i)*AW +: AW] = q[i];
      checks++;
      if (count !== CW'(q.size()) || position !== exp) begin
        errors++;
        $display("FAIL rand_data c=%0d cnt=%0d exp=%0d pos=%h exp=%h",
                 c, count, q.size(), position, exp);
      end
      checks++;
      if (full !== (q.size() == DP) || overflow !== m_ovf ||
          draining !== m_drain || rdValid !== (m_drain && q.size() > 0)) begin
        errors++;
        $display("FAIL rand_flags c=%0d got f=%b o=%b d=%b v=%b exp %b %b %b %b",
                 c, full, overflow, draining, rdValid, q.size() == DP,
                 m_ovf, m_drain, m_drain && q.size() > 0);
      end
      if (m_drain && q.size() > 0) begin
        checks++;
        if (rdData !== q[0]) begin
          errors++;
          $display("FAIL rand_rddata c=%0d got=%h exp=%h", c, rdData, q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill5();
    test_overflow();
    test_drain();
    test_frame_priority();
    test_write_drain();
    test_empty_drain();
    test_rst_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/corner_pos_buf.md
CORNER_POS_BUF -- requirements
Module: corner_pos_buf

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, width of one stored pixel address.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; legal range 2..64.
REQ-003 SHALL have parameter CNT_W, default $clog2(DEPTH+1), width of the occupancy count.
REQ-004 SHALL have port clk  in  1  rising-edge clock (one clock domain).
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port frameStart  in  1  one-cycle pulse that clears the buffer for a new frame.
REQ-007 SHALL have port matPoint  in  1  corner-valid strobe; refAddr is captured when high.
REQ-008 SHALL have port refAddr  in  ADDR_W  corner pixel address.
REQ-009 SHALL have port drainStart  in  1  pulse that ends collection and starts readout.
REQ-010 SHALL have port rdReq  in  1  pop request in DRAIN.
REQ-011 SHALL have port rdData  out  ADDR_W  head entry; valid when rdValid is high.
REQ-012 SHALL have port rdValid  out  1  high in DRAIN while count > 0.
REQ-013 SHALL have port position  out  DEPTH*ADDR_W  parallel image; entry 0 in the MSBs; entries at or above count read as zero.
REQ-014 SHALL have port count  out  CNT_W  current number of valid entries.
REQ-015 SHALL have port full  out  1  high when count == DEPTH.
REQ-016 SHALL have port overflow  out  1  sticky flag; set when a corner is dropped.
REQ-017 SHALL have port draining  out  1  high in the DRAIN state.

Function
REQ-018 SHALL use states COLLECT and DRAIN; COLLECT -> DRAIN on drainStart; DRAIN -> COLLECT on frameStart, or on the pop that empties the buffer.
REQ-019 SHALL, in COLLECT with matPoint high and count < DEPTH, write refAddr at wrPtr and increment wrPtr and count at the next edge.
REQ-020 SHALL, in COLLECT with matPoint high and full high, drop the write and set overflow; count is unchanged.
REQ-021 SHALL ignore matPoint in DRAIN and set overflow if matPoint is high there.
REQ-022 SHALL drive rdData combinationally from entry rdPtr; each cycle with rdReq && rdValid SHALL advance rdPtr and decrement count.
REQ-023 SHALL ignore rdReq when rdValid is low: no pointer change and no error.
REQ-024 SHALL wrap wrPtr and rdPtr modulo DEPTH; pointers SHALL be reset to 0 on entry to COLLECT.
REQ-025 SHALL drive position as entries in logical order from rdPtr, so that position always reflects the remaining unread corners.
REQ-026 SHALL give frameStart priority over all other inputs in the same cycle: clear count, pointers and overflow, enter COLLECT, and discard any simultaneous matPoint.
REQ-027 SHALL treat drainStart and matPoint in the same COLLECT cycle as a write followed by the transition, so the written entry is included in the drain.
REQ-028 SHALL, on drainStart with count == 0, enter DRAIN with rdValid low and return to COLLECT only on frameStart.
REQ-029 SHALL have write-to-visibility latency of 1 cycle (count, position) and pop latency of 1 cycle.

Reset
REQ-030 SHALL, when rst is high at a clock edge, force state COLLECT, pointers 0, count 0, overflow 0 and all entries 0; rst overrides every other input.
REQ-031 SHALL, after reset, drive rdValid 0, full 0, draining 0 and position all-zero.

Structure
REQ-032 SHALL place the state enum and the default ADDR_W and DEPTH constants in the shared package fast9_pkg.
REQ-033 SHALL contain one sub-module, pos_regfile: a DEPTH x ADDR_W register array with one synchronous write port and an async full-width read.
REQ-034 SHALL contain no latches; all storage SHALL be clocked on clk.

Verification
REQ-035 Reset, then matPoint with addresses 0x0101..0x0105 -> count = 5, position entries 0..4 = 0x0101..0x0105, remaining entries 0.
REQ-036 Seventeen writes with DEPTH = 16 -> full = 1 after the 16th, overflow = 1 after the 17th, entry 15 holds the 16th address.
REQ-037 Fill 16, drainStart, rdReq held for 16 cycles -> rdData in write order, rdValid drops and state returns to COLLECT after the last pop.
REQ-038 Same-cycle frameStart and matPoint with 3 entries stored -> count = 0, overflow = 0, state COLLECT, no entry written.
REQ-039 Same-cycle matPoint(0x7FFF) and drainStart with 2 entries stored -> count = 3, draining = 1, third rdData = 0x7FFF.
REQ-040 rst asserted mid-drain with count = 7 -> next cycle count = 0, draining = 0, position = 0.
